operand_selector: RTL

//  Consumer end of the register-button decode interface. Takes the one-cycle selection strobe
//  and the register number from the button decoder, and collects three picks in order:

---
 rtl/operand_selector.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/operand_selector.sv
// operand_selector: collects src A, src B and dst register picks and issues them as one triple.
// Optional feature macro: LED_BLINK_EN (blinks the LEDs while a selection is incomplete).
module operand_selector #(
    parameter int NUM_REGS  = 4,
    parameter int BLINK_DIV = 22
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                is_reg,
    input  logic [2:0]          reg_num,
    input  logic                clear,
    input  logic                op_ready,
    output logic                op_valid,
    output logic [2:0]          src_a,
    output logic [2:0]          src_b,
    output logic [2:0]          dst,
    output logic [1:0]          stage,
    output logic [NUM_REGS-1:0] led
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        WAIT_D = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [3:0] LP_MAXR = 4'(NUM_REGS);

    state_t              r_state;
    logic                r_pending;
    logic                r_valid;
    logic [2:0]          r_src_a;
    logic [2:0]          r_src_b;
    logic [2:0]          r_dst;
    logic [NUM_REGS-1:0] r_led;

    state_t              w_state_n;
    logic                w_pending_n;
    logic                w_valid_n;
    logic [2:0]          w_src_a_n;
    logic [2:0]          w_src_b_n;
    logic [2:0]          w_dst_n;
    logic [NUM_REGS-1:0] w_led_n;
    logic [NUM_REGS-1:0] w_onehot;
    logic                w_pick_ok;
    logic                w_sample;
    logic                w_phase;

    // Register number k lights bit k-1; zero lights nothing.
    function automatic logic [NUM_REGS-1:0] f_onehot(input logic [2:0] r);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int k = 1; k <= NUM_REGS; k++) begin
            if (int'(r) == k) begin
                v[k-1] = 1'b1;
            end
        end
        return v;
    endfunction

    assign w_pick_ok = ({1'b0, reg_num} != 4'd0) && ({1'b0, reg_num} <= LP_MAXR);
    assign w_sample  = r_pending && w_pick_ok;

`ifdef LED_BLINK_EN
    logic [BLINK_DIV-1:0] r_cnt;
    logic [BLINK_DIV-1:0] w_cnt_n;

    assign w_cnt_n = r_cnt + 1'b1;
    assign w_phase = w_cnt_n[BLINK_DIV-1];

    // Free-running blink divider; its MSB gates the LEDs while picking.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_n;
        end
    end
`else
    // Steady build: the blink phase is permanently on.
    assign w_phase = (BLINK_DIV > 0);
`endif

    // Next-state, pick capture and handshake; clear overrides everything.
    always_comb begin
        w_state_n   = r_state;
        w_pending_n = 1'b0;
        w_src_a_n   = r_src_a;
        w_src_b_n   = r_src_b;
        w_dst_n     = r_dst;
        if (clear) begin
            w_state_n = WAIT_A;
            w_src_a_n = '0;
            w_src_b_n = '0;
            w_dst_n   = '0;
        end else begin
            unique case (r_state)
                WAIT_A: begin
                    w_pending_n = is_reg;
                    if (w_sample) begin
                        w_src_a_n = reg_num;
                        w_state_n = WAIT_B;
                    end
                end
                WAIT_B: begin
                    w_pending_n = is_reg;
                    if (w_sample) begin
                        w_src_b_n = reg_num;
                        w_state_n = WAIT_D;
                    end
                end
                WAIT_D: begin
                    w_pending_n = is_reg;
                    if (w_sample) begin
                        w_dst_n     = reg_num;
                        w_state_n   = ISSUE;
                        w_pending_n = 1'b0;
                    end
                end
                ISSUE: begin
                    if (r_valid && op_ready) begin
                        w_state_n = WAIT_A;
                        w_src_a_n = '0;
                        w_src_b_n = '0;
                        w_dst_n   = '0;
                    end
                end
                default: begin
                    w_state_n = WAIT_A;
                end
            endcase
        end
    end

    // LED drive and valid are derived from the next field values so they track them.
    always_comb begin
        w_onehot  = f_onehot(w_src_a_n) | f_onehot(w_src_b_n) | f_onehot(w_dst_n);
        w_valid_n = (w_state_n == ISSUE);
        w_led_n   = '0;
        unique case (w_state_n)
            WAIT_A:         w_led_n = '0;
            WAIT_B, WAIT_D: w_led_n = w_onehot & {NUM_REGS{w_phase}};
            ISSUE:          w_led_n = w_onehot;
            default:        w_led_n = '0;
        endcase
    end

    // All state and outputs registered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= WAIT_A;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_dst     <= '0;
            r_led     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_pending <= w_pending_n;
            r_valid   <= w_valid_n;
            r_src_a   <= w_src_a_n;
            r_src_b   <= w_src_b_n;
            r_dst     <= w_dst_n;
            r_led     <= w_led_n;
        end
    end

    assign op_valid = r_valid;
    assign src_a    = r_src_a;
    assign src_b    = r_src_b;
    assign dst      = r_dst;
    assign stage    = r_state;
    assign led      = r_led;

endmodule
